// File: rtl/apb_regspace_bridge_if.sv
// rtl/apb_regspace_bridge_if.sv - APB4 slave bus plus register-space rreq/rack/wreq channels
interface apb_regspace_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] p_addr;
    logic [2:0]        p_prot;
    logic              p_sel;
    logic              p_enable;
    logic              p_write;
    logic [DATA_W-1:0] p_wdata;
    logic [STRB_W-1:0] p_strb;
    logic              p_ready;
    logic [DATA_W-1:0] p_rdata;
    logic              p_slverr;

    logic [ADDR_W-1:0] rreq_addr;
    logic              rreq_vld;
    logic              rreq_rdy;
    logic [DATA_W-1:0] rack_data;
    logic              rack_err;
    logic              rack_vld;
    logic              rack_rdy;
    logic [ADDR_W-1:0] wreq_addr;
    logic [DATA_W-1:0] wreq_data;
    logic [STRB_W-1:0] wreq_strb;
    logic              wreq_vld;
    logic              wreq_rdy;

    // Bridge view: APB slave upstream, register-space requester downstream
    modport slave (
        input  p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
        output p_ready, p_rdata, p_slverr,
        output rreq_addr, rreq_vld, input rreq_rdy,
        input  rack_data, rack_err, rack_vld, output rack_rdy,
        output wreq_addr, wreq_data, wreq_strb, wreq_vld, input wreq_rdy
    );

    modport master (
        output p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
        input  p_ready, p_rdata, p_slverr,
        input  rreq_addr, rreq_vld, output rreq_rdy,
        output rack_data, rack_err, rack_vld, input rack_rdy,
        input  wreq_addr, wreq_data, wreq_strb, wreq_vld, output wreq_rdy
    );
endinterface

// File: rtl/apb_regspace_bridge.sv
// rtl/apb_regspace_bridge.sv - APB4 slave to register-space request/acknowledge bridge
module apb_regspace_bridge #(
    parameter int          ADDR_W      = 16,
    parameter int          DATA_W      = 32,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned SPACE_SIZE  = 'h1000,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int          SECURE_ONLY = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    apb_regspace_bridge_if.slave bus
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int ALIGN_W = $clog2(STRB_W);
    localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RACK, RESP} state_t;

    state_t            state, state_nxt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              p_ready_q;
    logic              p_slverr_q;
    logic [DATA_W-1:0] p_rdata_q;

    logic              setup;
    logic              addr_err;
    logic              expired;
    logic              req_hs;
    logic              resp_go;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] wdata_masked;
    logic [ADDR_W:0]   off_ext;

    assign setup = bus.p_sel & ~bus.p_enable;

    // One extra bit makes addresses below the base wrap above the window
    assign off_ext  = {1'b0, bus.p_addr} - (ADDR_W + 1)'(BASE_ADDR);
    assign addr_err = (off_ext >= (ADDR_W + 1)'(SPACE_SIZE))
                   || (bus.p_addr[ALIGN_W-1:0] != '0)
                   || ((SECURE_ONLY != 0) && bus.p_prot[1]);

    always_comb begin
        wdata_masked = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wdata_masked[8*i +: 8] = bus.p_wdata[8*i +: 8] & {8{bus.p_strb[i]}};
        end
    end

    // Counter keeps running from REQ into RACK, so it can pass TIMEOUT_CYC-1
    assign expired = (TIMEOUT_CYC != 0) && (32'(cnt_q) >= TIMEOUT_CYC - 1);
    assign req_hs  = wr_q ? bus.wreq_rdy : bus.rreq_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        resp_go   = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        case (state)
            IDLE: begin
                if (setup) begin
                    if (addr_err) begin
                        state_nxt = RESP;
                        resp_go   = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (req_hs) begin
                    if (wr_q) begin
                        state_nxt = RESP;
                        resp_go   = 1'b1;
                    end else begin
                        state_nxt = RACK;
                    end
                end else if (expired) begin
                    state_nxt = RESP;
                    resp_go   = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            RACK: begin
                if (bus.rack_vld) begin
                    state_nxt = RESP;
                    resp_go   = 1'b1;
                    resp_err  = bus.rack_err;
                    resp_data = bus.rack_err ? '0 : bus.rack_data;
                end else if (expired) begin
                    state_nxt = RESP;
                    resp_go   = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            cnt_q      <= '0;
            p_ready_q  <= 1'b0;
            p_slverr_q <= 1'b0;
            p_rdata_q  <= '0;
        end else begin
            p_ready_q  <= resp_go;
            p_slverr_q <= resp_err;
            p_rdata_q  <= resp_data;
            if (state == IDLE && setup) begin
                wr_q    <= bus.p_write;
                addr_q  <= off_ext[ADDR_W-1:0];
                wdata_q <= bus.p_write ? wdata_masked : '0;
                strb_q  <= bus.p_write ? bus.p_strb : '0;
            end
            if (state == IDLE && state_nxt == REQ) begin
                cnt_q <= '0;
            end else if (state == REQ || state == RACK) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.p_ready   = p_ready_q;
    assign bus.p_slverr  = p_slverr_q;
    assign bus.p_rdata   = p_rdata_q;
    assign bus.rreq_addr = addr_q;
    assign bus.rreq_vld  = (state == REQ) & ~wr_q;
    assign bus.rack_rdy  = (state == RACK);
    assign bus.wreq_addr = addr_q;
    assign bus.wreq_data = wdata_q;
    assign bus.wreq_strb = strb_q;
    assign bus.wreq_vld  = (state == REQ) & wr_q;
endmodule

// File: tb/tb_apb_regspace_bridge.sv
// tb/tb_apb_regspace_bridge.sv - scoreboard bench for apb_regspace_bridge
module tb_apb_regspace_bridge;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int T      = 8;
    localparam int BASE   = 0;
    localparam int SIZE   = 'h1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_regspace_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_regspace_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .SPACE_SIZE(SIZE),
        .TIMEOUT_CYC(T), .SECURE_ONLY(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {logic err; logic [31:0] rdata; int waits;} resp_t;
    typedef struct {logic wr; logic [15:0] addr; logic [31:0] data; logic [3:0] strb;} ds_t;

    resp_t resp_q[$];
    ds_t   ds_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cur_dreq = 0;
    int    cur_dack = 0;
    logic [31:0] cur_rdata = '0;
    logic  cur_rerr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Downstream register-space responder; verifies every request handshake
    int  req_k = 0;
    int  ack_k = 0;
    logic hs;
    ds_t de;
    always @(negedge clk) begin
        if (bus.rreq_vld || bus.wreq_vld) begin
            hs = (req_k >= cur_dreq);
            bus.rreq_rdy = hs;
            bus.wreq_rdy = hs;
            req_k++;
            if (hs) begin
                check("req_expected", ds_q.size() != 0, 1);
                if (ds_q.size() != 0) begin
                    de = ds_q.pop_front();
                    check("req_dir", bus.wreq_vld, de.wr);
                    if (de.wr) begin
                        check("wreq_addr", bus.wreq_addr, de.addr);
                        check("wreq_data", bus.wreq_data, de.data);
                        check("wreq_strb", bus.wreq_strb, de.strb);
                    end else begin
                        check("rreq_addr", bus.rreq_addr, de.addr);
                    end
                end
            end
        end else begin
            bus.rreq_rdy = 1'b0;
            bus.wreq_rdy = 1'b0;
            req_k = 0;
        end
        if (bus.rack_rdy) begin
            bus.rack_vld  = (ack_k >= cur_dack);
            bus.rack_data = bus.rack_vld ? cur_rdata : $urandom;
            bus.rack_err  = bus.rack_vld ? cur_rerr : 1'b0;
            ack_k++;
        end else begin
            bus.rack_vld = 1'b0;
            bus.rack_err = 1'b0;
            ack_k = 0;
        end
    end

    // APB response monitor: pops the scoreboard on each p_ready pulse
    int    acc = 0;
    resp_t mr;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            acc = 0;
        end else begin
            if (bus.p_sel && !bus.p_enable) acc = 0;
            if (bus.p_ready) begin
                check("resp_expected", resp_q.size() != 0, 1);
                if (resp_q.size() != 0) begin
                    mr = resp_q.pop_front();
                    check("p_slverr", bus.p_slverr, mr.err);
                    check("p_rdata", bus.p_rdata, mr.rdata);
                    check("wait_states", acc, mr.waits);
                end
                acc = 0;
            end else begin
                check("p_rdata_idle", bus.p_rdata, 0);
                acc++;
            end
        end
    end

    task automatic issue(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int dreq,
                         input int dack, input logic [31:0] rdata, input logic rerr);
        resp_t r;
        ds_t   d;
        logic  bad;
        int    a;
        int    c;
        a   = int'(addr);
        bad = (a < BASE) || (a >= BASE + SIZE) || (a % 4 != 0) || prot[1];
        d.wr   = wr;
        d.addr = 16'(a - BASE);
        d.data = '0;
        d.strb = wr ? strb : 4'h0;
        for (int i = 0; i < 4; i++) d.data[8*i +: 8] = (wr && strb[i]) ? wdata[8*i +: 8] : 8'h00;
        r.err   = 1'b1;
        r.rdata = '0;
        if (bad) begin
            r.waits = 0;
        end else if (wr) begin
            if (dreq < T) begin
                r.err = 1'b0;
                r.waits = dreq + 1;
                ds_q.push_back(d);
            end else begin
                r.waits = T;
            end
        end else if (dreq >= T) begin
            r.waits = T;
        end else begin
            ds_q.push_back(d);
            c = dreq + 1 + dack;
            if (c <= T - 1 || dack == 0) begin
                r.err   = rerr;
                r.rdata = rerr ? 32'h0 : rdata;
                r.waits = c + 1;
            end else begin
                r.waits = (dreq + 2 > T) ? dreq + 2 : T;
            end
        end
        resp_q.push_back(r);
        @(negedge clk);
        cur_dreq  = bad ? 0 : dreq;
        cur_dack  = dack;
        cur_rdata = rdata;
        cur_rerr  = rerr;
        bus.p_sel    = 1'b1;
        bus.p_enable = 1'b0;
        bus.p_addr   = addr;
        bus.p_write  = wr;
        bus.p_wdata  = wdata;
        bus.p_strb   = strb;
        bus.p_prot   = prot;
        @(negedge clk);
        bus.p_enable = 1'b1;
    endtask

    task automatic finish_xfer();
        int n = 0;
        while (!bus.p_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("xfer_completes", n < 40, 1);
    endtask

    task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int dreq,
                        input int dack, input logic [31:0] rdata, input logic rerr);
        issue(addr, wr, wdata, strb, prot, dreq, dack, rdata, rerr);
        finish_xfer();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.p_sel    = 1'b0;
            bus.p_enable = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {bus.p_ready, bus.p_slverr, bus.rreq_vld, bus.wreq_vld, bus.rack_rdy}, 0);
        check({tag, "_rdata"}, bus.p_rdata, 0);
        check({tag, "_wdata"}, bus.wreq_data, 0);
        check({tag, "_addr"}, {bus.rreq_addr, bus.wreq_addr, bus.wreq_strb}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] addr;
        logic [2:0]  prot;
        int          kind;
        int          n;
        bus.p_sel = 0; bus.p_enable = 0; bus.p_write = 0; bus.p_addr = 0;
        bus.p_wdata = 0; bus.p_strb = 0; bus.p_prot = 0;
        bus.rreq_rdy = 0; bus.wreq_rdy = 0; bus.rack_vld = 0; bus.rack_err = 0; bus.rack_data = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        xfer(16'h0010, 1, 32'hA5A5_1234, 4'b0101, 3'b000, 0, 0, 0, 0);
        xfer(16'h0020, 0, 32'h0, 4'hF, 3'b000, 3, 2, 32'hDEAD_BEEF, 0);
        idle(1);
        xfer(16'h1000, 0, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0);
        xfer(16'h0002, 0, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0);
        xfer(16'h0030, 1, 32'h1111_2222, 4'hF, 3'b010, 0, 0, 0, 0);
        xfer(16'h0040, 0, 32'h0, 4'h0, 3'b000, 9, 0, 32'h7777_7777, 0);
        xfer(16'h0044, 1, 32'hCAFE_F00D, 4'hF, 3'b000, 7, 0, 0, 0);
        xfer(16'h0048, 1, 32'hCAFE_F00D, 4'hF, 3'b000, 8, 0, 0, 0);
        xfer(16'h004C, 0, 32'h0, 4'h0, 3'b000, 7, 0, 32'h0BAD_CAFE, 0);
        xfer(16'h0050, 0, 32'h0, 4'h0, 3'b000, 0, 1, 32'h0000_1234, 1);
        idle(2);

        issue(16'h0060, 0, 32'h0, 4'h0, 3'b000, 0, 6, 32'h5555_AAAA, 0);
        n = 0;
        while (!bus.rack_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_rack", bus.rack_rdy, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        resp_q.delete();
        ds_q.delete();
        idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        xfer(16'h0070, 1, 32'h89AB_CDEF, 4'b1110, 3'b000, 1, 0, 0, 0);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)      addr = 16'(SIZE + ($urandom_range(0, 16'hEFFF) & ~32'h3));
            else if (kind == 1) addr = 16'(($urandom_range(0, SIZE / 4 - 1) * 4) + $urandom_range(1, 3));
            else                addr = 16'($urandom_range(0, SIZE / 4 - 1) * 4);
            prot = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 6) != 0) prot[1] = 1'b0;
            xfer(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), prot,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 2),
                 $urandom, 1'($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        check("resp_queue_drained", resp_q.size(), 0);
        check("req_queue_drained", ds_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
